// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: strobes one column at a time, debounces the row lines and
// emits one key event per physical press, with held status until release.
module keypad_scan_controller #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(SCAN_DIV - 32'd1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(32'd1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [SW-1:0] SCNT_ONE  = SW'(32'd1);
    localparam logic [3:0]    NO_KEY    = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // Lowest-index low row wins when several rows are pulled low together.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] pat);
        logic [1:0] idx;
        casez (pat)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]    row_meta_r, row_sync_r;
    state_t        state_r, state_s;
    logic [1:0]    col_r, col_s;
    logic [DW-1:0] dcnt_r, dcnt_s;
    logic [SW-1:0] scnt_r, scnt_s;
    logic [3:0]    pat_r, pat_s;
    logic [3:0]    key_code_r, key_code_s;
    logic          key_valid_r, key_valid_s;
    logic          key_held_r, key_held_s;
    logic [3:0]    shift_col_r, shift_col_s;

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_r <= NO_KEY;
            row_sync_r <= NO_KEY;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
        end
    end

    // Next-state and next-output logic for scan, debounce and hold.
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        dcnt_s      = dcnt_r;
        scnt_s      = scnt_r;
        pat_s       = pat_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;

        case (state_r)
            ST_SCAN: begin
                // Rows are only sampled at the end of the dwell, after the column settles.
                if (dcnt_r == DCNT_LAST) begin
                    if (row_sync_r == NO_KEY) begin
                        dcnt_s = '0;
                        col_s  = col_r + 2'd1;
                    end else begin
                        pat_s   = row_sync_r;
                        scnt_s  = '0;
                        dcnt_s  = '0;
                        state_s = ST_DEBOUNCE;
                    end
                end else begin
                    dcnt_s = dcnt_r + DCNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (row_sync_r != pat_r) begin
                    state_s = ST_SCAN;
                    dcnt_s  = '0;
                end else if (scnt_r == SCNT_LAST) begin
                    state_s     = ST_HELD;
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                    key_code_s  = {lowest_low_row(pat_r), col_r};
                    scnt_s      = '0;
                end else begin
                    scnt_s = scnt_r + SCNT_ONE;
                end
            end
            ST_HELD: begin
                if (row_sync_r == NO_KEY) begin
                    if (scnt_r == SCNT_LAST) begin
                        state_s    = ST_SCAN;
                        key_held_s = 1'b0;
                        col_s      = col_r + 2'd1;
                        dcnt_s     = '0;
                        scnt_s     = '0;
                    end else begin
                        scnt_s = scnt_r + SCNT_ONE;
                    end
                end else begin
                    scnt_s = '0;
                end
            end
            default: begin
                state_s = ST_SCAN;
                dcnt_s  = '0;
                scnt_s  = '0;
            end
        endcase

        shift_col_s = ~(4'b0001 << col_s);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SCAN;
            col_r       <= 2'd0;
            dcnt_r      <= '0;
            scnt_r      <= '0;
            pat_r       <= NO_KEY;
            key_code_r  <= 4'b0000;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            shift_col_r <= 4'b1110;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            dcnt_r      <= dcnt_s;
            scnt_r      <= scnt_s;
            pat_r       <= pat_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
            shift_col_r <= shift_col_s;
        end
    end

    assign shift_col = shift_col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Scans the 4x4 vending-machine keypad, debounces presses and releases, and hands one clean key event per physical press to the vending-machine FSM. It drives the active-low column strobes `shift_col` and reads the active-low `row` lines. It sits between the keypad pins and the price/credit logic that feeds the D0–D5 seven-segment displays.

## Interface
- `SCAN_DIV`, 16: clock cycles each column stays strobed. Legal range ≥2.
- `DEBOUNCE_CYCLES`, 8: consecutive stable cycles required to accept a press or a release. Legal range ≥1.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows, active-low (4'b1111 = no key); asynchronous to `clk`.
- `shift_col`  out  4  column strobe, one-cold active-low (exactly one bit 0).
- `key_code`  out  4  {row_idx[1:0], col_idx[1:0]} of the accepted key; holds its value until the next accept.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_held`  out  1  high from accept until release is accepted.

## Operation
- **Input sync:** `row` passes through a 2-flop synchronizer to give `row_s`; both flops reset to 4'b1111. All decisions below use `row_s`.
- **Column strobe:** column index `col` (0..3); `shift_col = ~(4'b0001 << col)`.
- **Counters:** dwell counter `dcnt` of width $clog2(SCAN_DIV); stability counter `scnt` of width $clog2(DEBOUNCE_CYCLES)+1; captured pattern `pat[3:0]`.
- **SCAN:**
  - `dcnt` increments every cycle.
  - When `dcnt == SCAN_DIV-1` and `row_s == 4'b1111`: `dcnt` ← 0 and `col` ← `col`+1 (3 wraps to 0).
  - When `dcnt == SCAN_DIV-1` and `row_s != 4'b1111`: `pat` ← `row_s`, `scnt` ← 0, go to DEBOUNCE. `col` is frozen.
  - `row_s` is ignored at all other `dcnt` values; this is the column settle time.
- **DEBOUNCE:**
  - Each cycle with `row_s == pat`: `scnt` increments.
  - Any cycle with `row_s != pat`: return to SCAN with `dcnt` ← 0 and the same `col`; no event is produced.
  - When `scnt == DEBOUNCE_CYCLES-1` and `row_s == pat`: go to HELD. In the same edge, `key_valid` ← 1, `key_held` ← 1, and `key_code` ← {index of the lowest 0 bit of `pat`, `col`}.
- **HELD:**
  - `key_valid` returns to 0 after one cycle. `col` stays frozen.
  - `scnt` counts consecutive cycles with `row_s == 4'b1111`; any other value clears it to 0.
  - When `scnt == DEBOUNCE_CYCLES-1` and `row_s == 4'b1111`: go to SCAN, `key_held` ← 0, `col` ← `col`+1, `dcnt` ← 0.
  - Changes in the pressed pattern while in HELD never produce a second `key_valid`.
- **Multiple rows low:** the lowest-index low row wins. Example: `pat` = 4'b1001 gives row_idx = 1.
- **Reset:** `reset` overrides every state and counter on the next edge. Reset values:
  - state = SCAN, `col` = 0, `shift_col` = 4'b1110
  - `key_code` = 4'b0000, `key_valid` = 0, `key_held` = 0
  - `dcnt` = 0, `scnt` = 0, `pat` = 4'b1111, sync flops = 4'b1111
- A reset during DEBOUNCE or HELD never emits `key_valid`.

## Timing
- All outputs are registered; there is no combinational path from `row` to any output.
- Input to `row_s`: 2 cycles.
- With `row` steady in SCAN, a column steps every `SCAN_DIV` cycles, so a full sweep takes 4·`SCAN_DIV` cycles.
- Press latency: `key_valid` is high in the cycle after edge E0+`DEBOUNCE_CYCLES`, where E0 is the edge that entered DEBOUNCE.
- Worst-case press latency from a stable `row` change: 2 + 4·`SCAN_DIV` + `DEBOUNCE_CYCLES` + 1 cycles.
- Release latency: `key_held` falls `DEBOUNCE_CYCLES` edges after `row_s` first reads 4'b1111 continuously.
- `key_valid` is never high on two consecutive cycles.
- Exactly one `key_valid` is produced per DEBOUNCE→HELD transition.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=3, `clk` period 2.
1. **Reset and idle scan:** `reset`=1 for 3 cycles, then `row`=4'b1111 → `shift_col`=1110 with `key_valid`=`key_held`=0 and `key_code`=0000. Strobe then steps 1110→1101→1011→0111→1110, 4 cycles per column.
2. **Single press:** drive `row`=1101 steadily while `shift_col`=1011 → one `key_valid` pulse with `key_code`=4'b0110 and `key_held`=1. `shift_col` stays at 1011 while held.
3. **Bounce rejection:** toggle `row` between 1110 and 1111 every 1–2 cycles for 40 cycles → `key_valid` never asserts. Scanning continues afterward.
4. **Release:** after scenario 2, set `row`=1111 → `key_held` falls 3 edges after `row_s`=1111, and `shift_col` advances to 0111. Exactly one `key_valid` is seen over the whole press/hold/release.
5. **Multi-row:** drive `row`=1001 on column 3 (`shift_col`=0111) → `key_code`=4'b0111.
6. **Reset mid-operation:** assert `reset` for 1 cycle during DEBOUNCE, and separately during HELD → no `key_valid`; the next cycle shows `shift_col`=1110 and `key_held`=0.
